lcd_mode_sched: RTL and testbench
=================================

LCD_MODE_SCHED -- requirements
Module: lcd_mode_sched

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port en_tick, input, 1, one-clk strobe pacing all LCD timing (nominal 1 kHz).
REQ-004 The block SHALL have port btn_mode, input, 1, one-clk debounced mode-advance pulse.
REQ-005 The block SHALL have ports char_clk, char_stop and char_alarm, input, 8 each, ASCII from the clock, stopwatch and alarm mode blocks.
REQ-006 The block SHALL have port index, output, 5, character position 0-31 (0-15 line 1, 16-31 line 2) broadcast to all mode blocks.
REQ-007 The block SHALL have port mode, output, 2, active mode: 0 clock, 1 stopwatch, 2 alarm.
REQ-008 The block SHALL have ports lcd_rs, lcd_rw and lcd_e, output, 1 each, HD44780 control; lcd_rw SHALL be tied to 0.
REQ-009 The block SHALL have port lcd_data, output, 8, HD44780 data bus.

Function
REQ-010 Every LCD transfer SHALL take exactly 2 ticks: tick A drives lcd_rs/lcd_data and sets lcd_e=1; tick B clears lcd_e and keeps lcd_rs/lcd_data stable.
REQ-011 The FSM SHALL have the states INIT, ADDR1, LINE1, ADDR2, LINE2, and CLR when the clear feature is compiled in.
REQ-012 INIT SHALL send 0x38, 0x0C, 0x06 and 0x01 (rs=0), then wait 2 extra ticks, then go to ADDR1.
REQ-013 ADDR1 SHALL send 0x80 (rs=0); LINE1 SHALL send 16 characters (rs=1) for index 0-15.
REQ-014 ADDR2 SHALL send 0xC0 (rs=0); LINE2 SHALL send index 16-31; after index 31 the FSM SHALL return to ADDR1 (wrap).
REQ-015 index SHALL update on tick B of each transfer to the next position, wrapping 31->0; the character sampled at tick A SHALL come from the index value held since the previous tick B, giving at least 1 tick of settling for the mode blocks' registered outputs.
REQ-016 The character source SHALL be selected by mode: 0 char_clk, 1 char_stop, 2 char_alarm; mode 3 is unreachable.
REQ-017 A btn_mode pulse SHALL set a pending flag; further pulses while pending SHALL be ignored.
REQ-018 A pending change SHALL be applied only at entry to ADDR1: mode advances 0->1->2->0 and pending clears.
REQ-019 A mode change SHALL never occur mid-frame.
REQ-020 A btn_mode pulse coincident with the ADDR1 entry SHALL be applied at that entry.
REQ-021 btn_mode pulses during INIT SHALL be latched and applied at the first ADDR1.
REQ-022 Without en_tick, all outputs and state SHALL hold.

Reset
REQ-023 While rst=0, the state SHALL be INIT (first command), index=0, mode=0, pending=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-024 An assertion of rst mid-transfer SHALL drop lcd_e immediately, with no glitch back high, and INIT SHALL restart on release.

Configuration
REQ-025 When LCD_CLEAR_ON_MODE_EN is defined, an applied mode change SHALL first enter CLR: send 0x01, wait 2 extra ticks, then send 0x80.
REQ-026 When LCD_CLEAR_ON_MODE_EN is undefined, CLR SHALL not exist and ADDR1 SHALL follow directly.

Verification
REQ-027 The bench SHALL release reset and apply a tick every 4 clk: lcd_data SHALL show 0x38, 0x0C, 0x06, 0x01, 0x80 with one lcd_e pulse each, lcd_rs=0.
REQ-028 The bench SHALL set mode 0 with char_clk=0x41: 16 rs=1 writes of 0x41, then 0xC0, then 16 more writes, then 0x80, with index 0..31 in order.
REQ-029 The bench SHALL pulse btn_mode at index 5: the frame SHALL finish in mode 0, and mode=1 SHALL appear at the next 0x80 and char_stop data SHALL follow.
REQ-030 The bench SHALL pulse btn_mode three times within one frame: mode SHALL advance by exactly 1.
REQ-031 The bench SHALL assert rst during tick A of a LINE2 write: lcd_e=0 and index=0 SHALL hold at once, and the 0x38 sequence SHALL restart after release.
REQ-032 With LCD_CLEAR_ON_MODE_EN defined, the bench SHALL trigger a mode change: the sequence 0x01, a 2-tick gap, then 0x80 SHALL occur.

Source files
------------

// File: rtl/lcd_mode_sched_if.sv
// Signal bundle between the LCD scheduler and its surroundings: tick/button
// inputs, the three mode character sources, and the HD44780 control/data bus.
interface lcd_mode_sched_if;
  logic       en_tick;
  logic       btn_mode;
  logic [7:0] char_clk;
  logic [7:0] char_stop;
  logic [7:0] char_alarm;
  logic [4:0] index;
  logic [1:0] mode;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (
    output en_tick, btn_mode, char_clk, char_stop, char_alarm,
    input  index, mode, lcd_rs, lcd_rw, lcd_e, lcd_data
  );

  modport slave (
    input  en_tick, btn_mode, char_clk, char_stop, char_alarm,
    output index, mode, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
endinterface

// File: rtl/lcd_mode_sched.sv
// HD44780 refresh scheduler: init sequence, then endless two-line frames from the
// selected mode block. Optional LCD_CLEAR_ON_MODE_EN clears the display on mode change.
module lcd_mode_sched (
  input  logic            clk,
  input  logic            rst,
  lcd_mode_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ADDR1 = 3'd1,
    ST_LINE1 = 3'd2,
    ST_ADDR2 = 3'd3,
    ST_LINE2 = 3'd4
`ifdef LCD_CLEAR_ON_MODE_EN
    , ST_CLR = 3'd5
`endif
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      2'd3:    init_cmd = 8'h01;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      2'd0:    next_mode = 2'd1;
      2'd1:    next_mode = 2'd2;
      default: next_mode = 2'd0;
    endcase
  endfunction

  state_t     state_r, state_s;
  logic       phase_r, phase_s;
  logic [2:0] step_r, step_s;
  logic [4:0] index_r, index_s;
  logic [1:0] mode_r, mode_s;
  logic       pending_r, pending_s;
  logic       lcd_rs_r, lcd_rs_s;
  logic       lcd_e_r, lcd_e_s;
  logic [7:0] lcd_data_r, lcd_data_s;
  logic [7:0] char_s, cmd_s;
  logic       cmd_rs_s, wait_s, wait_last_s, frame_end_s;

  // Next-state, transfer sequencing and mode-change application
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    step_s      = step_r;
    index_s     = index_r;
    mode_s      = mode_r;
    pending_s   = pending_r | bus.btn_mode;
    lcd_rs_s    = lcd_rs_r;
    lcd_e_s     = lcd_e_r;
    lcd_data_s  = lcd_data_r;
    cmd_s       = 8'h00;
    cmd_rs_s    = 1'b0;
    wait_s      = 1'b0;
    wait_last_s = 1'b0;
    frame_end_s = 1'b0;

    case (mode_r)
      2'd0:    char_s = bus.char_clk;
      2'd1:    char_s = bus.char_stop;
      2'd2:    char_s = bus.char_alarm;
      default: char_s = bus.char_clk;
    endcase

    case (state_r)
      ST_INIT: begin
        if (step_r < 3'd4) begin
          cmd_s = init_cmd(step_r[1:0]);
        end else begin
          wait_s      = 1'b1;
          wait_last_s = (step_r == 3'd5);
        end
      end
      ST_ADDR1: cmd_s = 8'h80;
      ST_LINE1, ST_LINE2: begin
        cmd_s    = char_s;
        cmd_rs_s = 1'b1;
      end
      ST_ADDR2: cmd_s = 8'hC0;
`ifdef LCD_CLEAR_ON_MODE_EN
      ST_CLR: begin
        if (step_r == 3'd0) begin
          cmd_s = 8'h01;
        end else begin
          wait_s      = 1'b1;
          wait_last_s = (step_r == 3'd2);
        end
      end
`endif
      default: cmd_s = 8'h00;
    endcase

    if (bus.en_tick && wait_s) begin
      if (wait_last_s) begin
        step_s = 3'd0;
        if (state_r == ST_INIT) begin
          frame_end_s = 1'b1;
        end else begin
          state_s = ST_ADDR1;
        end
      end else begin
        step_s = step_r + 3'd1;
      end
    end else if (bus.en_tick && !phase_r) begin
      lcd_rs_s   = cmd_rs_s;
      lcd_data_s = cmd_s;
      lcd_e_s    = 1'b1;
      phase_s    = 1'b1;
    end else if (bus.en_tick) begin
      // Tick B: strobe falls with rs/data held; index moves only after character writes
      lcd_e_s = 1'b0;
      phase_s = 1'b0;
      case (state_r)
        ST_INIT:  step_s = step_r + 3'd1;
        ST_ADDR1: state_s = ST_LINE1;
        ST_LINE1: begin
          index_s = index_r + 5'd1;
          if (index_r == 5'd15) begin
            state_s = ST_ADDR2;
          end else begin
            state_s = ST_LINE1;
          end
        end
        ST_ADDR2: state_s = ST_LINE2;
        ST_LINE2: begin
          index_s = index_r + 5'd1;
          if (index_r == 5'd31) begin
            frame_end_s = 1'b1;
          end else begin
            state_s = ST_LINE2;
          end
        end
`ifdef LCD_CLEAR_ON_MODE_EN
        ST_CLR:   step_s = step_r + 3'd1;
`endif
        default:  state_s = ST_INIT;
      endcase
    end else begin
      phase_s = phase_r;
    end

    // Frame boundary is the only place a pending (or coincident) mode request lands
    if (frame_end_s) begin
      if (pending_s) begin
        mode_s    = next_mode(mode_r);
        pending_s = 1'b0;
`ifdef LCD_CLEAR_ON_MODE_EN
        state_s   = ST_CLR;
`else
        state_s   = ST_ADDR1;
`endif
      end else begin
        state_s = ST_ADDR1;
      end
    end else begin
      mode_s = mode_r;
    end
  end

  // State and registered LCD outputs; reset drops lcd_e asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_INIT;
      phase_r    <= 1'b0;
      step_r     <= 3'd0;
      index_r    <= 5'd0;
      mode_r     <= 2'd0;
      pending_r  <= 1'b0;
      lcd_rs_r   <= 1'b0;
      lcd_e_r    <= 1'b0;
      lcd_data_r <= 8'h00;
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      step_r     <= step_s;
      index_r    <= index_s;
      mode_r     <= mode_s;
      pending_r  <= pending_s;
      lcd_rs_r   <= lcd_rs_s;
      lcd_e_r    <= lcd_e_s;
      lcd_data_r <= lcd_data_s;
    end
  end

  assign bus.index    = index_r;
  assign bus.mode     = mode_r;
  assign bus.lcd_rs   = lcd_rs_r;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = lcd_e_r;
  assign bus.lcd_data = lcd_data_r;

endmodule

// File: tb/tb_lcd_mode_sched.sv
// Randomized bench for lcd_mode_sched: every LCD write is matched against a
// frame-level model of the expected command/character stream, mode and timing.
module tb_lcd_mode_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;

  lcd_mode_sched_if bus ();
  lcd_mode_sched dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] idx;
    int         gap;
    bit         is_char;
    logic [1:0] mode;
  } wr_t;

  wr_t        exp_q[$];
  int         n_cmp = 0, n_err = 0;
  int         cyc = 0, ticks = 0, last_wr_tick = 0, rise_tick = 0, frame_m = 0;
  int         next_gap = 1;
  logic [1:0] mode_m = 2'd0;
  bit         pending_m = 1'b0, btn_req = 1'b0, prev_e = 1'b0;
  bit         want_rst = 1'b0, done_rst = 1'b0;
  logic [7:0] rise_data;
  logic       rise_rs;
  logic [7:0] cur [0:2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input int idx, input bit is_char);
    wr_t e;
    e.rs = rs; e.data = data; e.idx = idx[4:0]; e.gap = next_gap;
    e.is_char = is_char; e.mode = mode_m;
    exp_q.push_back(e);
    next_gap = (!rs && data == 8'h01) ? 4 : 2;
  endtask

  task automatic gen_frame();
    if (pending_m) begin
      mode_m    = (mode_m == 2'd2) ? 2'd0 : mode_m + 2'd1;
      pending_m = 1'b0;
`ifdef LCD_CLEAR_ON_MODE_EN
      push(1'b0, 8'h01, 0, 1'b0);
`endif
    end
    push(1'b0, 8'h80, 0, 1'b0);
    for (int i = 0; i < 16; i++) push(1'b1, 8'h00, i, 1'b1);
    push(1'b0, 8'hC0, 16, 1'b0);
    for (int i = 16; i < 32; i++) push(1'b1, 8'h00, i, 1'b1);
    frame_m++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mode_m = 2'd0; pending_m = 1'b0; next_gap = 1;
    push(1'b0, 8'h38, 0, 1'b0);
    push(1'b0, 8'h0C, 0, 1'b0);
    push(1'b0, 8'h06, 0, 1'b0);
    push(1'b0, 8'h01, 0, 1'b0);
  endtask

  task automatic drive_chars();
    bus.char_clk = cur[0]; bus.char_stop = cur[1]; bus.char_alarm = cur[2];
  endtask

  task automatic on_write();
    wr_t e;
    if (exp_q.size() == 0) gen_frame();
    e = exp_q.pop_front();
    chk("rs", bus.lcd_rs, e.rs);
    chk("data", bus.lcd_data, e.is_char ? cur[e.mode] : e.data);
    chk("index", bus.index, e.idx);
    chk("mode", bus.mode, e.mode);
    chk("gap", ticks - last_wr_tick, e.gap);
    chk("rw", bus.lcd_rw, 1'b0);
    last_wr_tick = ticks; rise_tick = ticks;
    rise_data = bus.lcd_data; rise_rs = bus.lcd_rs;
    // Scenario schedule keyed on frame number and character position
    if (e.is_char) begin
      if (frame_m == 2 && e.idx == 5'd5) btn_req = 1'b1;
      if (frame_m == 4 && (e.idx == 5'd3 || e.idx == 5'd10 || e.idx == 5'd20)) btn_req = 1'b1;
      if (frame_m >= 5 && frame_m <= 8 && $urandom_range(0, 24) == 0) btn_req = 1'b1;
      if (frame_m == 9 && !done_rst && e.idx >= 5'd16) begin
        want_rst = 1'b1; done_rst = 1'b1;
      end
    end
    if (frame_m >= 2) begin
      for (int i = 0; i < 3; i++) cur[i] = 8'($urandom);
      drive_chars();
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (rst) begin
      if (bus.lcd_e && !prev_e) begin
        on_write();
      end else if (!bus.lcd_e && prev_e) begin
        chk("e_width", ticks - rise_tick, 1);
        chk("hold_data", bus.lcd_data, rise_data);
        chk("hold_rs", bus.lcd_rs, rise_rs);
      end
    end
    prev_e = bus.lcd_e;
    bus.en_tick = (cyc % 4 == 0);
    if (bus.en_tick) ticks++;
    bus.btn_mode = btn_req && rst;
    if (bus.btn_mode) pending_m = 1'b1;
    btn_req = 1'b0;
  endtask

  task automatic release_rst();
    while (bus.en_tick) cycle();
    rst = 1'b1;
    last_wr_tick = ticks;
    prev_e = 1'b0;
  endtask

  initial begin
    bus.en_tick = 1'b0;
    bus.btn_mode = 1'b0;
    cur[0] = 8'h41; cur[1] = 8'h53; cur[2] = 8'h61;
    drive_chars();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", bus.lcd_e, 1'b0);
    chk("rst_rs", bus.lcd_rs, 1'b0);
    chk("rst_rw", bus.lcd_rw, 1'b0);
    chk("rst_data", bus.lcd_data, 8'h00);
    chk("rst_index", bus.index, 5'd0);
    chk("rst_mode", bus.mode, 2'd0);
    model_reset();
    release_rst();

    for (int c = 0; c < 30000 && frame_m < 12; c++) begin
      cycle();
      if (want_rst) begin
        want_rst = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_e", bus.lcd_e, 1'b0);
        chk("mid_rst_index", bus.index, 5'd0);
        chk("mid_rst_mode", bus.mode, 2'd0);
        chk("mid_rst_data", bus.lcd_data, 8'h00);
        repeat (6) cycle();
        chk("mid_rst_e_hold", bus.lcd_e, 1'b0);
        model_reset();
        release_rst();
      end
    end
    chk("frames_done", frame_m >= 12, 1'b1);
    chk("reset_hit", done_rst, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
